// File: rtl/addsub_op_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_op_ctrl_if
// Description : Request and result handshake bundle for addsub_op_ctrl.
//               Request side : in_valid / in_ready / in_a / in_b / in_sub
//                              (+ in_acc when ADDSUB_ACCUM_EN is defined)
//               Result side  : out_valid / out_ready / out_mag / out_neg /
//                              out_carry
//               master = requester and result consumer, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_op_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_sub;
`ifdef ADDSUB_ACCUM_EN
   logic       in_acc;
`endif
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_mag;
   logic       out_neg;
   logic       out_carry;

`ifdef ADDSUB_ACCUM_EN
   modport master (
      output in_valid, in_a, in_b, in_sub, in_acc, out_ready,
      input  in_ready, out_valid, out_mag, out_neg, out_carry
   );
   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_acc, out_ready,
      output in_ready, out_valid, out_mag, out_neg, out_carry
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_mag, out_neg, out_carry
   );
   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_mag, out_neg, out_carry
   );
`endif
endinterface
`default_nettype wire

// File: rtl/addsub_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addsub_op_ctrl
// Description : Sequencing front-end for an external 8-bit combinational
//               adder-subtractor. Latches a request into registers driving
//               the adder, holds them for SETTLE_CYCLES, captures sum/flag,
//               converts a subtract result to sign + magnitude and hands it
//               downstream over a valid/ready handshake.
// Parameters  : SETTLE_CYCLES - adder settle window in cycles, legal 1..15
// Ports       : clk, rst        - clock, synchronous active-high reset
//               bus (slave)     - request / result handshakes
//               add_a/add_b/add_cin - registered adder operands (b is raw,
//                                 the adder inverts it when cin = 1)
//               add_s/add_cout  - adder sum; cout = carry (add) or
//                                 negative flag (subtract)
//               busy            - high whenever not idle
// Option      : ADDSUB_ACCUM_EN - adds in_acc and a 9-bit accumulator whose
//               low byte can replace in_a as operand A
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_op_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   addsub_op_ctrl_if.slave  bus,
   output logic [7:0]       add_a,
   output logic [7:0]       add_b,
   output logic             add_cin,
   input  logic [7:0]       add_s,
   input  logic             add_cout,
   output logic             busy
);

   localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CONV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic [3:0] r_cnt;
   logic [7:0] r_add_a;
   logic [7:0] r_add_b;
   logic       r_add_cin;
   logic [7:0] r_s;
   logic       r_c;
   logic [7:0] r_out_mag;
   logic       r_out_neg;
   logic       r_out_carry;

   logic       w_accept;
   logic       w_capture;
   logic       w_convert;
   logic       w_in_ready;
   logic       w_out_valid;
   logic       w_busy;
   logic [7:0] w_a_src;
   logic [7:0] w_mag;
   logic       w_neg;
   logic       w_carry;

`ifdef ADDSUB_ACCUM_EN
   logic [8:0] r_acc;
   assign w_a_src = bus.in_acc ? r_acc[7:0] : bus.in_a;
`else
   assign w_a_src = bus.in_a;
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and control strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_convert   = 1'b0;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
            if (bus.in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_CONV;
            end
         end
         ST_CONV: begin
            w_convert   = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Sign/magnitude conversion of the captured result. For subtract the
   // adder's cout marks a negative two's-complement sum, which is negated.
   // ------------------------------------------------------------------------
   always_comb begin
      w_mag   = r_s;
      w_neg   = 1'b0;
      w_carry = 1'b0;
      if (!r_add_cin) begin
         w_carry = r_c;
      end else if (r_c) begin
         w_mag = ~r_s + 8'd1;
         w_neg = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= 4'd0;
         r_add_a     <= 8'd0;
         r_add_b     <= 8'd0;
         r_add_cin   <= 1'b0;
         r_s         <= 8'd0;
         r_c         <= 1'b0;
         r_out_mag   <= 8'd0;
         r_out_neg   <= 1'b0;
         r_out_carry <= 1'b0;
      end else begin
         if (w_accept) begin
            r_add_a   <= w_a_src;
            r_add_b   <= bus.in_b;
            r_add_cin <= bus.in_sub;
            r_cnt     <= c_settle_load;
         end
         if (r_state == ST_EXEC && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_s <= add_s;
            r_c <= add_cout;
         end
         if (w_convert) begin
            r_out_mag   <= w_mag;
            r_out_neg   <= w_neg;
            r_out_carry <= w_carry;
         end
      end
   end

`ifdef ADDSUB_ACCUM_EN
   // Raw 9-bit result {flag, sum}; only the low byte feeds operand A.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= 9'd0;
      end else if (w_convert) begin
         r_acc <= {r_c, r_s};
      end
   end
`endif

   assign add_a         = r_add_a;
   assign add_b         = r_add_b;
   assign add_cin       = r_add_cin;
   assign busy          = w_busy;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_mag   = r_out_mag;
   assign bus.out_neg   = r_out_neg;
   assign bus.out_carry = r_out_carry;

endmodule
`default_nettype wire

// File: tb/tb_addsub_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_op_ctrl
// Description : Self-checking bench for addsub_op_ctrl. Two instances:
//               u_dut (SETTLE_CYCLES=1) and u_dut4 (SETTLE_CYCLES=4), each
//               wired to a behavioural adder. Expected results are queued on
//               request acceptance and compared on result handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_op_ctrl;

   typedef struct packed {
      logic [7:0] mag;
      logic       neg;
      logic       carry;
   } exp_t;

`ifdef ADDSUB_ACCUM_EN
   localparam bit ACC_ON = 1'b1;
`else
   localparam bit ACC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rst4;
   logic [7:0] add_a, add_b, add_s;
   logic       add_cin, add_cout, busy;
   logic [7:0] add_a4, add_b4, add_s4;
   logic       add_cin4, add_cout4, busy4;

   int         errors = 0;
   int         checks = 0;
   exp_t       q[$];
   exp_t       q4[$];
   logic [7:0] acc_s;

   addsub_op_ctrl_if bus ();
   addsub_op_ctrl_if bus4 ();

   addsub_op_ctrl #(.SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout), .busy(busy)
   );

   addsub_op_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(rst4), .bus(bus4),
      .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
      .add_s(add_s4), .add_cout(add_cout4), .busy(busy4)
   );

   // Adder: b inverted when cin=1; cout reports "negative" for subtract.
   function automatic logic [8:0] adder(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [8:0] r;
      r = {1'b0, a} + {1'b0, (cin ? ~b : b)} + {8'd0, cin};
      if (cin) r[8] = ~r[8];
      return r;
   endfunction

   // Arithmetic reference, independent of the adder encoding.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
      exp_t       e;
      logic [8:0] sum;
      e = '0;
      if (!sub) begin
         sum     = {1'b0, a} + {1'b0, b};
         e.mag   = sum[7:0];
         e.carry = sum[8];
      end else if (a >= b) begin
         e.mag = a - b;
      end else begin
         e.mag = b - a;
         e.neg = 1'b1;
      end
      return e;
   endfunction

   always_comb {add_cout, add_s}   = adder(add_a, add_b, add_cin);
   always_comb {add_cout4, add_s4} = adder(add_a4, add_b4, add_cin4);

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   // Present a request on u_dut, wait for acceptance, queue the expectation.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic acc, output bit ok);
      int         n;
      logic [7:0] a_used;
      logic [8:0] t;
      ok = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
`ifdef ADDSUB_ACCUM_EN
      bus.in_acc   = acc;
`endif
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout in_ready=%0b required 1", bus.in_ready);
         bus.in_valid = 1'b0;
         return;
      end
      a_used = (acc && ACC_ON) ? acc_s : a;
      q.push_back(model(a_used, b, sub));
      t     = adder(a_used, b, sub);
      acc_s = t[7:0];
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if ({add_a, add_b, add_cin} !== {a_used, b, sub}) begin
         errors++;
         $display("FAIL adder_inputs a=%0d b=%0d cin=%0b required a=%0d b=%0d cin=%0b",
                  add_a, add_b, add_cin, a_used, b, sub);
      end
      ok = 1'b1;
   endtask

   // Wait for out_valid on u_dut, check latency and result, complete handoff.
   task automatic wait_result(input int exp_lat, input string name);
      int   n;
      exp_t e;
      n = 0;
      while (!bus.out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || n != exp_lat) begin
         errors++;
         $display("FAIL %s_latency cycles=%0d valid=%0b required cycles=%0d", name, n, bus.out_valid, exp_lat);
         if (bus.out_valid !== 1'b1) return;
      end
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL %s_queue result present with empty queue, required queued entry", name);
      end else begin
         e = q.pop_front();
         if ({bus.out_mag, bus.out_neg, bus.out_carry} !== {e.mag, e.neg, e.carry}) begin
            errors++;
            $display("FAIL %s mag=%0d neg=%0b carry=%0b required mag=%0d neg=%0b carry=%0b",
                     name, bus.out_mag, bus.out_neg, bus.out_carry, e.mag, e.neg, e.carry);
         end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s_handoff out_valid=%0b in_ready=%0b required 0 1", name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst  = 1'b0;
      rst4 = 1'b0;
      checks++;
      if ({bus.in_ready, busy, bus.out_valid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_ctrl in_ready=%0b busy=%0b out_valid=%0b required 1 0 0",
                  bus.in_ready, busy, bus.out_valid);
      end
      checks++;
      if ({add_a, add_b, add_cin, bus.out_mag, bus.out_neg, bus.out_carry} !== 27'd0) begin
         errors++;
         $display("FAIL reset_regs a=%0d b=%0d cin=%0b mag=%0d neg=%0b carry=%0b required all 0",
                  add_a, add_b, add_cin, bus.out_mag, bus.out_neg, bus.out_carry);
      end
      checks++;
      if ({bus4.in_ready, busy4, bus4.out_valid, add_a4} !== {3'b100, 8'd0}) begin
         errors++;
         $display("FAIL reset_dut4 in_ready=%0b busy=%0b out_valid=%0b a=%0d required 1 0 0 0",
                  bus4.in_ready, busy4, bus4.out_valid, add_a4);
      end
   endtask

   task automatic test_add;
      bit ok;
      issue(8'd25, 8'd17, 1'b0, 1'b0, ok);
      if (ok) wait_result(2, "add_25_17");
      issue(8'd200, 8'd100, 1'b0, 1'b0, ok);
      if (ok) wait_result(2, "add_carry");
   endtask

   task automatic test_sub;
      bit ok;
      issue(8'd17, 8'd25, 1'b1, 1'b0, ok);
      if (ok) wait_result(2, "sub_neg");
      issue(8'd0, 8'd255, 1'b1, 1'b0, ok);
      if (ok) wait_result(2, "sub_0_255");
   endtask

   task automatic test_backpressure;
      bit   ok;
      int   n;
      exp_t e;
      issue(8'd25, 8'd17, 1'b1, 1'b0, ok);
      if (!ok) return;
      n = 0;
      while (!bus.out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid out_valid=%0b required 1", bus.out_valid);
         return;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.out_valid, bus.out_mag, bus.out_neg} !== {1'b1, 8'd8, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d valid=%0b mag=%0d neg=%0b required 1 8 0",
                     i, bus.out_valid, bus.out_mag, bus.out_neg);
         end
         if (i == 1) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'd99;
            bus.in_b     = 8'd1;
            bus.in_sub   = 1'b0;
         end
         if (i == 2) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready in_ready=%0b required 0", bus.in_ready);
            end
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL bp_queue empty queue, required queued entry");
      end else begin
         e = q.pop_front();
         if ({bus.out_mag, bus.out_neg, bus.out_carry} !== {e.mag, e.neg, e.carry}) begin
            errors++;
            $display("FAIL bp_result mag=%0d neg=%0b carry=%0b required mag=%0d neg=%0b carry=%0b",
                     bus.out_mag, bus.out_neg, bus.out_carry, e.mag, e.neg, e.carry);
         end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({busy, bus.out_valid, add_a, bus.out_mag} !== {1'b0, 1'b0, 8'd25, 8'd8}) begin
            errors++;
            $display("FAIL bp_after cycle=%0d busy=%0b valid=%0b a=%0d mag=%0d required 0 0 25 8",
                     i, busy, bus.out_valid, add_a, bus.out_mag);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      localparam int N = 6;
      logic [7:0] oa[N];
      logic [7:0] ob[N];
      logic       os[N];
      logic [8:0] t;
      exp_t       e;
      int         idx, got, cyc, last;
      for (int i = 0; i < N; i++) begin
         oa[i] = 8'($urandom_range(0, 255));
         ob[i] = 8'($urandom_range(0, 255));
         os[i] = 1'($urandom_range(0, 1));
      end
      oa[0] = 8'd255; ob[0] = 8'd1; os[0] = 1'b0;
      oa[1] = 8'd0;   ob[1] = 8'd0; os[1] = 1'b1;
      idx = 0; got = 0; cyc = 0; last = -1;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = oa[0];
      bus.in_b      = ob[0];
      bus.in_sub    = os[0];
`ifdef ADDSUB_ACCUM_EN
      bus.in_acc    = 1'b0;
`endif
      bus.out_ready = 1'b1;
      while ((idx < N || got < N) && cyc < 200) begin
         if (bus.out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_queue result present with empty queue");
            end else begin
               e = q.pop_front();
               if ({bus.out_mag, bus.out_neg, bus.out_carry} !== {e.mag, e.neg, e.carry}) begin
                  errors++;
                  $display("FAIL b2b_result n=%0d mag=%0d neg=%0b carry=%0b required mag=%0d neg=%0b carry=%0b",
                           got, bus.out_mag, bus.out_neg, bus.out_carry, e.mag, e.neg, e.carry);
               end
            end
            got++;
         end
         if (bus.in_ready && idx < N) begin
            q.push_back(model(oa[idx], ob[idx], os[idx]));
            t     = adder(oa[idx], ob[idx], os[idx]);
            acc_s = t[7:0];
            if (last >= 0) begin
               checks++;
               if (cyc - last != 4) begin
                  errors++;
                  $display("FAIL b2b_throughput spacing=%0d required 4", cyc - last);
               end
            end
            last = cyc;
            idx++;
         end else if (!bus.in_ready) begin
            if (idx < N) begin
               bus.in_a   = oa[idx];
               bus.in_b   = ob[idx];
               bus.in_sub = os[idx];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (got != N || q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count got=%0d pending=%0d required %0d 0", got, q.size(), N);
      end
   endtask

   task automatic test_rst_exec;
      bit seen;
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_a     = 8'd50;
      bus4.in_b     = 8'd3;
      bus4.in_sub   = 1'b0;
      checks++;
      if (bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_ready in_ready=%0b required 1", bus4.in_ready);
      end
      @(negedge clk);
      bus4.in_valid = 1'b0;
      checks++;
      if ({busy4, add_a4} !== {1'b1, 8'd50}) begin
         errors++;
         $display("FAIL rst_exec_busy busy=%0b a=%0d required 1 50", busy4, add_a4);
      end
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      checks++;
      if ({bus4.in_ready, busy4, add_a4} !== {2'b10, 8'd0}) begin
         errors++;
         $display("FAIL rst_exec_state in_ready=%0b busy=%0b a=%0d required 1 0 0",
                  bus4.in_ready, busy4, add_a4);
      end
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus4.out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec_no_valid out_valid seen=%0b required 0", seen);
      end
   endtask

   task automatic test_settle4;
      int   n;
      exp_t e;
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in_a     = 8'd60;
      bus4.in_b     = 8'd70;
      bus4.in_sub   = 1'b1;
      q4.push_back(model(8'd60, 8'd70, 1'b1));
      @(negedge clk);
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus4.out_valid !== 1'b1 || n != 5) begin
         errors++;
         $display("FAIL settle4_latency cycles=%0d valid=%0b required 5 1", n, bus4.out_valid);
      end
      checks++;
      e = q4.pop_front();
      if ({bus4.out_mag, bus4.out_neg, bus4.out_carry} !== {e.mag, e.neg, e.carry}) begin
         errors++;
         $display("FAIL settle4_result mag=%0d neg=%0b carry=%0b required mag=%0d neg=%0b carry=%0b",
                  bus4.out_mag, bus4.out_neg, bus4.out_carry, e.mag, e.neg, e.carry);
      end
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.out_ready = 1'b0;
   endtask

`ifdef ADDSUB_ACCUM_EN
   task automatic test_accum;
      bit ok;
      issue(8'd10, 8'd5, 1'b0, 1'b0, ok);
      if (ok) wait_result(2, "acc_seed");
      issue(8'd0, 8'd20, 1'b1, 1'b1, ok);
      if (ok) wait_result(2, "acc_sub");
   endtask
`endif

   initial begin
      rst            = 1'b1;
      rst4           = 1'b1;
      acc_s          = 8'd0;
      bus.in_valid   = 1'b0;
      bus.in_a       = 8'd0;
      bus.in_b       = 8'd0;
      bus.in_sub     = 1'b0;
      bus.out_ready  = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_a      = 8'd0;
      bus4.in_b      = 8'd0;
      bus4.in_sub    = 1'b0;
      bus4.out_ready = 1'b0;
`ifdef ADDSUB_ACCUM_EN
      bus.in_acc     = 1'b0;
      bus4.in_acc    = 1'b0;
`endif
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_back_to_back();
      test_rst_exec();
      test_settle4();
`ifdef ADDSUB_ACCUM_EN
      test_accum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
